// File: rtl/uart_deserialized.sv
// 8N1 UART receiver that assembles DATA_WIDTH_BYTES consecutive bytes into one
// wide word (first byte in the low bits) and reports it with a one-cycle pulse.
module uart_deserialized #(
  parameter int CLKS_PER_BIT     = 173,
  parameter int DATA_WIDTH_BYTES = 18,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_valid,
  output logic                          frame_error,
  output logic                          timeout,
  output logic                          busy
);

  localparam int WORD_W     = 8 * DATA_WIDTH_BYTES;
  localparam int GAP_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX    = (GAP_CYCLES > CLKS_PER_BIT) ? GAP_CYCLES : CLKS_PER_BIT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDX_W      = (DATA_WIDTH_BYTES > 1) ? $clog2(DATA_WIDTH_BYTES) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic              sync_reg;
  logic              rx_s_reg;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shift_reg, shift_next;
  logic [IDX_W-1:0]  byte_idx_reg, byte_idx_next;
  logic [WORD_W-1:0] asm_reg;
  logic [WORD_W-1:0] merged_word;
  logic [WORD_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              frame_error_reg, frame_error_next;
  logic              timeout_reg, timeout_next;
  logic              byte_store;
  logic              word_done;

  // Assembly register with the just-received byte dropped into its slot;
  // used both to update the slot and to publish a complete word in one edge.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH_BYTES; gi++) begin : g_slot
      assign merged_word[gi*8 +: 8] = (byte_idx_reg == IDX_W'(gi)) ? shift_reg
                                                                   : asm_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    byte_idx_next    = byte_idx_reg;
    byte_store       = 1'b0;
    word_done        = 1'b0;
    frame_error_next = 1'b0;
    timeout_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // A start edge takes priority over an expiring gap timer.
        if (!rx_s_reg) begin
          state_next   = START;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end else if (byte_idx_reg != '0) begin
          if (cnt_reg == GAP_LAST) begin
            timeout_next  = 1'b1;
            byte_idx_next = '0;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            byte_store = 1'b1;
            state_next = IDLE;
            if (byte_idx_reg == IDX_LAST) begin
              word_done     = 1'b1;
              byte_idx_next = '0;
            end else begin
              byte_idx_next = byte_idx_reg + 1'b1;
            end
          end else begin
            frame_error_next = 1'b1;
            byte_idx_next    = '0;
            state_next       = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      WAIT_HIGH: begin
        // Hold off until a break condition ends so it cannot look like a start.
        cnt_next = '0;
        if (rx_s_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg        <= 1'b1;
      rx_s_reg        <= 1'b1;
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      byte_idx_reg    <= '0;
      asm_reg         <= '0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      sync_reg        <= rx_in;
      rx_s_reg        <= sync_reg;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      byte_idx_reg    <= byte_idx_next;
      if (byte_store) begin
        asm_reg <= merged_word;
      end
      if (word_done) begin
        data_out_reg <= merged_word;
      end
      data_valid_reg  <= word_done;
      frame_error_reg <= frame_error_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign frame_error = frame_error_reg;
  assign timeout     = timeout_reg;
  assign busy        = (state_reg != IDLE) || (byte_idx_reg != '0);

endmodule

// File: tb/tb_uart_deserialized.sv
// Scoreboard bench for uart_deserialized: words are queued as they are sent
// and compared when data_valid pulses; pulse counters cover error paths.
module tb_uart_deserialized;

  localparam int CPB      = 8;
  localparam int NB       = 2;
  localparam int TOB      = 4;
  localparam int W        = 8 * NB;
  localparam int HALF_CLK = 25;
  localparam int CLK_P    = 2 * HALF_CLK;
  localparam int BIT_NOM  = CPB * CLK_P;   // 400
  localparam int BIT_FAST = 392;           // -2 %
  localparam int BIT_SLOW = 408;           // +2 %

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_in = 1'b1;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         frame_error;
  logic         timeout;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int dv_cnt = 0;
  int to_cyc = -1;
  logic [W-1:0] sb[$];

  uart_deserialized #(
    .CLKS_PER_BIT     (CPB),
    .DATA_WIDTH_BYTES (NB),
    .TIMEOUT_BITS     (TOB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #HALF_CLK clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each data_valid, counts pulses.
  initial begin
    logic [W-1:0] exp_w;
    bit busy_chk;
    busy_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_chk) begin
        check("busy_after_valid", 64'(busy), 64'd0);
        busy_chk = 1'b0;
      end
      if (frame_error) fe_cnt++;
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (data_valid) begin
        dv_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(data_valid), 64'd0);
        end else begin
          exp_w = sb.pop_front();
          $display("rx word 0x%04h (expected 0x%04h) at cycle %0d", data_out, exp_w, cyc);
          check("data_out", 64'(data_out), 64'(exp_w));
        end
        busy_chk = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
    rx_in = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #(bit_t);
    end
    rx_in = stop_bit;
    #(bit_t);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int bit_t);
    @(posedge clk);
    #1;
    sb.push_back(w);
    send_byte(w[7:0], 1'b1, bit_t);
    send_byte(w[15:8], 1'b1, bit_t);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, to0, dv0, t0;
    logic [7:0] partial;
    logic [W-1:0] rw;
    int rate;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_frame_error", 64'(frame_error), 64'd0);
    check("reset_timeout", 64'(timeout), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Two bytes back to back
    fe0 = fe_cnt; to0 = to_cnt;
    send_word(16'h1234, BIT_NOM);
    #(20 * CLK_P);
    drain("s1_drain");
    check("s1_no_frame_error", 64'(fe_cnt - fe0), 64'd0);
    check("s1_no_timeout", 64'(to_cnt - to0), 64'd0);

    // Bad stop bit, line held low, then a good word
    fe0 = fe_cnt; dv0 = dv_cnt;
    @(posedge clk);
    #1;
    send_byte(8'hA5, 1'b0, BIT_NOM);
    #(30 * CLK_P);
    rx_in = 1'b1;
    #(10 * CLK_P);
    check("s2_frame_error", 64'(fe_cnt - fe0), 64'd1);
    check("s2_no_valid_a5", 64'(dv_cnt - dv0), 64'd0);
    send_word(16'h0201, BIT_NOM);
    #(20 * CLK_P);
    drain("s2_drain");

    // Inter-byte gap timeout
    to0 = to_cnt;
    @(posedge clk);
    #1;
    t0 = cyc;
    send_byte(8'h55, 1'b1, BIT_NOM);
    #(40 * CLK_P);
    check("s3_timeout_count", 64'(to_cnt - to0), 64'd1);
    check("s3_timeout_cycle", 64'(to_cyc), 64'(t0 + 9 * CPB + CPB / 2 + 3 + TOB * CPB));
    send_word(16'h7766, BIT_NOM);
    #(20 * CLK_P);
    drain("s3_drain");

    // Short low glitch while idle
    fe0 = fe_cnt; to0 = to_cnt; dv0 = dv_cnt;
    @(posedge clk);
    #1;
    rx_in = 1'b0;
    #(2 * CLK_P);
    rx_in = 1'b1;
    #(40 * CLK_P);
    check("s4_no_frame_error", 64'(fe_cnt - fe0), 64'd0);
    check("s4_no_timeout", 64'(to_cnt - to0), 64'd0);
    check("s4_no_valid", 64'(dv_cnt - dv0), 64'd0);
    check("s4_idle_busy", 64'(busy), 64'd0);
    send_word(16'hC33C, BIT_NOM);
    #(20 * CLK_P);
    drain("s4_drain");

    // Reset in the middle of the second byte of 0xBEEF
    fe0 = fe_cnt; to0 = to_cnt; dv0 = dv_cnt;
    partial = 8'hBE;
    @(posedge clk);
    #1;
    send_byte(8'hEF, 1'b1, BIT_NOM);
    rx_in = 1'b0;
    #(BIT_NOM);
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      #(BIT_NOM);
    end
    check("s5_busy_mid_word", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s5_rst_data_out", 64'(data_out), 64'd0);
    check("s5_rst_data_valid", 64'(data_valid), 64'd0);
    check("s5_rst_frame_error", 64'(frame_error), 64'd0);
    check("s5_rst_timeout", 64'(timeout), 64'd0);
    check("s5_rst_busy", 64'(busy), 64'd0);
    rx_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #(20 * CLK_P);
    send_word(16'hCAFE, BIT_NOM);
    #(20 * CLK_P);
    drain("s5_drain");
    check("s5_one_valid", 64'(dv_cnt - dv0), 64'd1);
    check("s5_no_errors", 64'((fe_cnt - fe0) + (to_cnt - to0)), 64'd0);

    // Random words at +/-2 % bit-rate error
    fe0 = fe_cnt; to0 = to_cnt; dv0 = dv_cnt;
    for (int n = 0; n < 16; n++) begin
      rate = ($urandom_range(0, 1) == 1) ? BIT_SLOW : BIT_FAST;
      rw = W'($urandom);
      send_word(rw, rate);
      #(BIT_NOM);
    end
    #(20 * CLK_P);
    drain("s6_drain");
    check("s6_valid_count", 64'(dv_cnt - dv0), 64'd16);
    check("s6_no_frame_error", 64'(fe_cnt - fe0), 64'd0);
    check("s6_no_timeout", 64'(to_cnt - to0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_deserialized.md
# uart_deserialized

Multi-byte UART receiver: the host-side/loopback counterpart of the record transmitter `uart_serialized`. It samples a single 8N1 serial line and assembles `DATA_WIDTH_BYTES` consecutive bytes into one wide word. It presents each completed word with a one-cycle valid pulse. It sits between the board RX pin and the record checker or command decoder; it recovers the 18-byte time-tag records the tagger streams out.

## Interface
- `CLKS_PER_BIT`, 173: clock cycles per UART bit; minimum 4.
- `DATA_WIDTH_BYTES`, 18: bytes per assembled word; minimum 1.
- `TIMEOUT_BITS`, 20: maximum idle gap between bytes of one word, in bit periods.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `rx_in`  input  1  serial line; idle high; asynchronous to `clk`.
- `data_out`  output  8*DATA_WIDTH_BYTES  last complete word; first received byte in `[7:0]`, last byte in the top byte.
- `data_valid`  output  1  one-cycle pulse when `data_out` is updated.
- `frame_error`  output  1  one-cycle pulse when a stop bit is sampled low.
- `timeout`  output  1  one-cycle pulse when a partial word is discarded because of the inter-byte gap limit.
- `busy`  output  1  high while a byte is in flight or a partial word is held.

## Operation
- `rx_in` passes through a 2-FF synchronizer. All decisions use the synchronized value `rx_s`.
- Bit FSM: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `rx_s`=0 -> START, bit counter cleared.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample. 0 -> DATA. 1 -> IDLE as a false start: no error, and a partial word is kept.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 samples, LSB first, shifted into the byte register. After the 8th sample -> STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - 1: the byte is written to slot `byte_idx` of the assembly register. If `byte_idx == DATA_WIDTH_BYTES-1`, the assembly register is copied to `data_out`, `data_valid` pulses and `byte_idx` is cleared. Otherwise `byte_idx` increments. Next state IDLE.
    - 0: `frame_error` pulses, the partial word is discarded (`byte_idx`=0), next state WAIT_HIGH.
  - WAIT_HIGH: stays until `rx_s`=1, then -> IDLE. This prevents a break condition from restarting reception.
- Gap timer: runs only in IDLE with `byte_idx`≠0, and clears on leaving IDLE. On reaching `TIMEOUT_BITS*CLKS_PER_BIT` cycles: `timeout` pulses, `byte_idx`=0, and the assembly register contents are ignored.
- `busy` = (state≠IDLE) or (`byte_idx`≠0).
- `data_out` holds its value between words. It is never partially updated.
- Counters: the cycle counter is sized for `max(CLKS_PER_BIT, TIMEOUT_BITS*CLKS_PER_BIT)`. `byte_idx` is sized for `DATA_WIDTH_BYTES` and never exceeds `DATA_WIDTH_BYTES-1`.

## Timing
- Reset values: all outputs 0 (`data_out`, `data_valid`, `frame_error`, `timeout`, `busy`); FSM in IDLE; `byte_idx`=0; synchronizer flops 1.
- A reset asserted mid-byte or mid-word discards everything immediately; no pulse is generated.
- Start detect lags the falling edge of `rx_in` by 2–3 cycles (synchronizer).
- Data bit k is sampled `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT` cycles after start detect. The stop bit is sampled at `+9*CLKS_PER_BIT`.
- `data_valid` and the new `data_out` appear on the clock edge that samples the final stop bit. `data_valid` is high for exactly one cycle.
- `frame_error` and `timeout` are registered one-cycle pulses. They are never asserted in the same cycle as `data_valid`.
- If the gap timer expires in the same cycle a start is detected, the start wins: no timeout, and the word continues.
- Back-to-back frames with zero idle bits are received without loss: STOP -> IDLE -> START in consecutive cycles.

## Test plan
- Bench parameters for all scenarios: `CLKS_PER_BIT`=8, `DATA_WIDTH_BYTES`=2, `TIMEOUT_BITS`=4.
- Bytes 0x34 then 0x12, back-to-back -> one `data_valid` pulse, `data_out`=0x1234, `busy` returns 0 the next cycle.
- Byte 0xA5 sent with stop bit 0, line held low 30 cycles, then bytes 0x01, 0x02 -> one `frame_error` pulse, no `data_valid` for 0xA5, then `data_out`=0x0201.
- Byte 0x55, idle 40 cycles, then 0x66, 0x77 -> `timeout` pulses 32 cycles after the 0x55 stop sample, then `data_out`=0x7766.
- A 2-cycle low glitch on `rx_in` while idle -> no pulses, no state change; a following valid word decodes normally.
- `reset` asserted halfway through the second byte of 0xBEEF, then 0xCAFE sent -> only `data_out`=0xCAFE is reported; no `data_valid` for the interrupted word; outputs are 0 during reset.
- Line with ±2% bit-rate error (period 7.84/8.16 cycles), 16 random words -> all decoded correctly, no errors.
